// File: rtl/neighbor_bank_write_arbiter.sv
// neighbor_bank_write_arbiter
// Takes a bundle of neighbor writes per valid/ready handshake and maps each lane to a buffer bank
// using a row-skewed hash. It grants at most one write per bank per cycle. Lanes that lose a bank
// conflict, or that target a stalled bank, are held and retried. A new bundle is accepted only
// when every lane of the previous bundle has been written.
`timescale 1ns/1ps
module neighbor_bank_write_arbiter #(
  parameter int BANK_COUNT = 32,
  parameter int TILE_SIZE  = 256,
  parameter int IN_PORTS   = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ROW_SKEW   = 3,
  localparam int RCW = $clog2(TILE_SIZE),
  localparam int BW  = $clog2(BANK_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_value  [IN_PORTS],
  input  logic [RCW-1:0]        in_row    [IN_PORTS],
  input  logic [RCW-1:0]        in_column [IN_PORTS],
  input  logic [IN_PORTS-1:0]   in_we,
  input  logic [BANK_COUNT-1:0] bank_ready,
  output logic [RCW-1:0]        buf_row    [BANK_COUNT],
  output logic [RCW-1:0]        buf_column [BANK_COUNT],
  output logic [DATA_WIDTH-1:0] buf_data   [BANK_COUNT],
  output logic [BANK_COUNT-1:0] buf_we,
  output logic                  busy,
  output logic [15:0]           conflict_cycles
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t                state_r, state_next_s;
  logic [IN_PORTS-1:0]   pending_r, next_pending_s;
  logic [DATA_WIDTH-1:0] held_value_r [IN_PORTS];
  logic [RCW-1:0]        held_row_r   [IN_PORTS];
  logic [RCW-1:0]        held_col_r   [IN_PORTS];

  logic [IN_PORTS-1:0]   cand_mask_s;
  logic [DATA_WIDTH-1:0] cand_value_s [IN_PORTS];
  logic [RCW-1:0]        cand_row_s   [IN_PORTS];
  logic [RCW-1:0]        cand_col_s   [IN_PORTS];
  logic [BW-1:0]         cand_bank_s  [IN_PORTS];
  logic [IN_PORTS-1:0]   lost_s;
  logic                  capture_s;

  logic [BANK_COUNT-1:0] win_we_s;
  logic [RCW-1:0]        win_row_s   [BANK_COUNT];
  logic [RCW-1:0]        win_col_s   [BANK_COUNT];
  logic [DATA_WIDTH-1:0] win_data_s  [BANK_COUNT];

  // Row-skewed bank hash. Only the low BW bits matter, so all arithmetic wraps at BANK_COUNT.
  function automatic logic [BW-1:0] bank_hash(input logic [RCW-1:0] row, input logic [RCW-1:0] col);
    logic [BW-1:0] skew_v;
    skew_v = BW'(32'(row) * ROW_SKEW);
    return BW'(col) + skew_v;
  endfunction

  assign in_ready  = (state_r == ST_IDLE);
  assign busy      = (state_r == ST_DRAIN);
  assign capture_s = (state_r == ST_IDLE) && in_valid;

  // Candidate source: held lanes while draining, otherwise the offered bundle (only when valid).
  always_comb begin
    cand_mask_s  = '0;
    cand_value_s = '{default: '0};
    cand_row_s   = '{default: '0};
    cand_col_s   = '{default: '0};
    if (state_r == ST_DRAIN) begin
      cand_mask_s  = pending_r;
      cand_value_s = held_value_r;
      cand_row_s   = held_row_r;
      cand_col_s   = held_col_r;
    end else if (in_valid) begin
      cand_mask_s  = in_we;
      cand_value_s = in_value;
      cand_row_s   = in_row;
      cand_col_s   = in_column;
    end else begin
      cand_mask_s  = '0;
    end
  end

  // Target bank of every candidate lane.
  always_comb begin
    for (int i = 0; i < IN_PORTS; i++) begin
      cand_bank_s[i] = bank_hash(cand_row_s[i], cand_col_s[i]);
    end
  end

  // Fixed-priority arbitration: the lowest lane claims a free, ready bank; the others are held.
  always_comb begin
    win_we_s   = '0;
    win_row_s  = '{default: '0};
    win_col_s  = '{default: '0};
    win_data_s = '{default: '0};
    lost_s     = '0;
    for (int i = 0; i < IN_PORTS; i++) begin
      if (cand_mask_s[i]) begin
        if (!win_we_s[cand_bank_s[i]] && bank_ready[cand_bank_s[i]]) begin
          win_we_s[cand_bank_s[i]]   = 1'b1;
          win_row_s[cand_bank_s[i]]  = cand_row_s[i];
          win_col_s[cand_bank_s[i]]  = cand_col_s[i];
          win_data_s[cand_bank_s[i]] = cand_value_s[i];
        end else begin
          lost_s[i] = 1'b1;
        end
      end else begin
        lost_s[i] = 1'b0;
      end
    end
  end

  // Next state: stay draining while any candidate lane is still unwritten.
  always_comb begin
    next_pending_s = lost_s;
    if (lost_s != '0) begin
      state_next_s = ST_DRAIN;
    end else begin
      state_next_s = ST_IDLE;
    end
  end

  // State, pending mask and held lane fields. Held fields load only when a bundle is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      pending_r    <= '0;
      held_value_r <= '{default: '0};
      held_row_r   <= '{default: '0};
      held_col_r   <= '{default: '0};
    end else begin
      state_r   <= state_next_s;
      pending_r <= next_pending_s;
      if (capture_s) begin
        held_value_r <= in_value;
        held_row_r   <= in_row;
        held_col_r   <= in_column;
      end
    end
  end

  // Registered per-bank write port. Banks without a winner are driven to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_we     <= '0;
      buf_row    <= '{default: '0};
      buf_column <= '{default: '0};
      buf_data   <= '{default: '0};
    end else begin
      buf_we     <= win_we_s;
      buf_row    <= win_row_s;
      buf_column <= win_col_s;
      buf_data   <= win_data_s;
    end
  end

  // Saturating count of cycles that end with writes still held.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cycles <= 16'd0;
    end else if ((next_pending_s != '0) && (conflict_cycles != 16'hFFFF)) begin
      conflict_cycles <= conflict_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_neighbor_bank_write_arbiter.sv
// Self-checking bench for neighbor_bank_write_arbiter. A queue-based model of the bundle/bank rules
// is checked against the DUT on every negative clock edge. Directed literal checks pin the model.
`timescale 1ns/1ps
module tb_neighbor_bank_write_arbiter;
  localparam int BANKS = 32;
  localparam int PORTS = 8;
  localparam int SKEW  = 3;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_value  [PORTS];
  logic [7:0]       in_row    [PORTS];
  logic [7:0]       in_column [PORTS];
  logic [PORTS-1:0] in_we;
  logic [BANKS-1:0] bank_ready;
  logic [7:0]       buf_row    [BANKS];
  logic [7:0]       buf_column [BANKS];
  logic [7:0]       buf_data   [BANKS];
  logic [BANKS-1:0] buf_we;
  logic             busy;
  logic [15:0]      conflict_cycles;

  int checks   = 0;
  int failures = 0;

  neighbor_bank_write_arbiter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_row(in_row), .in_column(in_column), .in_we(in_we),
    .bank_ready(bank_ready), .buf_row(buf_row), .buf_column(buf_column),
    .buf_data(buf_data), .buf_we(buf_we), .busy(busy), .conflict_cycles(conflict_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int lane; logic [7:0] value; logic [7:0] row; logic [7:0] col; } lane_t;
  lane_t pend_q[$];
  lane_t cand_q[$];
  lane_t keep_q[$];
  lane_t t;
  logic [BANKS-1:0] exp_we;
  logic [7:0] exp_row [BANKS];
  logic [7:0] exp_col [BANKS];
  logic [7:0] exp_data[BANKS];
  int  exp_cnt  = 0;
  bit  exp_ready = 1'b1;
  bit  model_on  = 1'b0;
  int  bk;
  bit  bad;
  int  bad_bank;

  function automatic int bank_of(int r, int c);
    return (c + ((r * SKEW) % BANKS)) % BANKS;
  endfunction

  // Check outputs launched at the last rising edge, then advance the model with the inputs
  // the DUT will sample at the next rising edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("buf_we", buf_we, exp_we);
      chk("in_ready", in_ready, exp_ready);
      chk("busy", busy, !exp_ready);
      chk("conflict_cycles", conflict_cycles, exp_cnt);
      bad = 1'b0;
      bad_bank = 0;
      for (int b = 0; b < BANKS; b++) begin
        if (!bad && (buf_row[b] !== exp_row[b] || buf_column[b] !== exp_col[b] ||
                     buf_data[b] !== exp_data[b])) begin
          bad = 1'b1;
          bad_bank = b;
        end
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL buf_fields bank=%0d actual row/col/data=%0h/%0h/%0h expected=%0h/%0h/%0h at %0t",
                 bad_bank, buf_row[bad_bank], buf_column[bad_bank], buf_data[bad_bank],
                 exp_row[bad_bank], exp_col[bad_bank], exp_data[bad_bank], $time);
      end
    end
    exp_we = '0;
    for (int b = 0; b < BANKS; b++) begin
      exp_row[b] = 8'd0; exp_col[b] = 8'd0; exp_data[b] = 8'd0;
    end
    if (reset) begin
      pend_q.delete();
      exp_cnt = 0;
    end else begin
      cand_q.delete();
      keep_q.delete();
      if (pend_q.size() != 0) begin
        cand_q = pend_q;
      end else if (in_valid) begin
        for (int i = 0; i < PORTS; i++) begin
          if (in_we[i]) begin
            t.lane = i; t.value = in_value[i]; t.row = in_row[i]; t.col = in_column[i];
            cand_q.push_back(t);
          end
        end
      end
      foreach (cand_q[k]) begin
        bk = bank_of(int'(cand_q[k].row), int'(cand_q[k].col));
        if (!exp_we[bk] && bank_ready[bk]) begin
          exp_we[bk]   = 1'b1;
          exp_row[bk]  = cand_q[k].row;
          exp_col[bk]  = cand_q[k].col;
          exp_data[bk] = cand_q[k].value;
        end else begin
          keep_q.push_back(cand_q[k]);
        end
      end
      pend_q = keep_q;
      if (pend_q.size() != 0 && exp_cnt < 65535) exp_cnt++;
    end
    exp_ready = (pend_q.size() == 0);
    model_on  = 1'b1;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < PORTS; i++) begin
      in_value[i] = 8'd0; in_row[i] = 8'd0; in_column[i] = 8'd0;
    end
  endtask

  initial begin
    logic [7:0] cols5 [PORTS];
    cols5 = '{8'd0, 8'd1, 8'd5, 8'd3, 8'd4, 8'd8, 8'd6, 8'd7};
    reset = 1'b1; in_valid = 1'b0; in_we = '0; bank_ready = '1;
    clear_lanes();
    tick(); tick();
    reset = 1'b0;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_buf_we", buf_we, 32'h0);
    chk("reset_count", conflict_cycles, 16'h0);

    // No conflict: row 0, columns 0..7 -> banks 0..7 in one cycle
    for (int i = 0; i < PORTS; i++) begin
      in_row[i] = 8'd0; in_column[i] = 8'(i); in_value[i] = 8'h10 + 8'(i);
    end
    in_we = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("noconf_we", buf_we, 32'h000000FF);
    chk("noconf_ready", in_ready, 1'b1);
    chk("noconf_data3", buf_data[3], 8'h13);

    // Full conflict: every lane hits bank 0, written in lane order
    for (int i = 0; i < PORTS; i++) begin
      in_row[i] = 8'd0; in_column[i] = 8'd0; in_value[i] = 8'(i);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      if (k > 0) tick();
      chk("fullconf_we", buf_we, 32'h1);
      chk("fullconf_data", buf_data[0], 8'(k));
      chk("fullconf_ready", in_ready, (k == 7) ? 1'b1 : 1'b0);
    end
    chk("fullconf_count", conflict_cycles, 16'd7);

    // Hash skew: (row1,col0) and (row0,col3) both map to bank 3
    clear_lanes();
    in_row[0] = 8'd1; in_column[0] = 8'd0; in_value[0] = 8'hA0;
    in_row[1] = 8'd0; in_column[1] = 8'd3; in_value[1] = 8'hA1;
    in_we = 8'h03; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("skew_we0", buf_we, 32'h8);
    chk("skew_data0", buf_data[3], 8'hA0);
    chk("skew_row0", buf_row[3], 8'd1);
    chk("skew_ready0", in_ready, 1'b0);
    tick();
    chk("skew_we1", buf_we, 32'h8);
    chk("skew_data1", buf_data[3], 8'hA1);
    chk("skew_col1", buf_column[3], 8'd3);
    chk("skew_ready1", in_ready, 1'b1);

    // Backpressure: bank 5 stalled for 4 cycles; second bundle must wait behind it
    bank_ready[5] = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      in_row[i] = 8'd0; in_column[i] = cols5[i]; in_value[i] = 8'h50 + 8'(i);
    end
    in_we = 8'hFF; in_valid = 1'b1;
    tick();
    chk("bp_first_we", buf_we, 32'h000001DB);
    chk("bp_first_ready", in_ready, 1'b0);
    for (int i = 0; i < PORTS; i++) begin
      in_row[i] = 8'd2; in_column[i] = 8'(i); in_value[i] = 8'h60 + 8'(i);
    end
    repeat (3) begin
      tick();
      chk("bp_stall_we", buf_we, 32'h0);
      chk("bp_stall_ready", in_ready, 1'b0);
    end
    bank_ready[5] = 1'b1;
    tick();
    chk("bp_lane2_we", buf_we, 32'h00000020);
    chk("bp_lane2_data", buf_data[5], 8'h52);
    tick();
    in_valid = 1'b0;
    chk("bp_second_we", buf_we, 32'h00003FC0);
    chk("bp_second_data", buf_data[6], 8'h60);
    chk("bp_count", conflict_cycles, 16'd12);

    // Saturation: one lane parked on stalled bank 0 for 70000 cycles
    clear_lanes();
    bank_ready[0] = 1'b0;
    in_value[0] = 8'h77; in_we = 8'h01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (70000) tick();
    chk("sat_count", conflict_cycles, 16'hFFFF);
    chk("sat_ready", in_ready, 1'b0);
    chk("sat_we", buf_we, 32'h0);

    // Reset in the middle of a drain drops the held write
    reset = 1'b1; bank_ready[0] = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_drain_we", buf_we, 32'h0);
    chk("rst_drain_ready", in_ready, 1'b1);
    chk("rst_drain_count", conflict_cycles, 16'h0);
    tick();
    chk("rst_drain_noissue", buf_we, 32'h0);

    // Empty bundle is accepted and writes nothing
    in_we = 8'h00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("empty_we", buf_we, 32'h0);
    chk("empty_ready", in_ready, 1'b1);
    tick(); tick();
    chk("empty_count", conflict_cycles, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
